// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch datapath, the BCD converter and the display.
// Everything that must agree on widths or the state encoding lives here.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int T_W        = 14;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int BCD_MAX    = 9999;

  // Largest value representable in the given number of BCD digits (10^digits - 1).
  function automatic int bcdLimit(input int digits);
    int result;
    result = 1;
    for (int i = 0; i < digits; i++) begin
      result = result * 10;
    end
    return result - 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added before the shift.
// The result stays within 4 bits, so no carry ever leaves the digit.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock behind valid/ready.
// Inputs above the display range are clamped to all nines and flagged through o_ovf.
module bin2bcd_seq
  import stopwatch_pkg::*;
#(
  parameter int BIN_W  = T_W,
  parameter int DIGITS = NUM_DIGITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_out_valid,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_ovf,
  output logic                  o_busy
);

  localparam int LIMIT = bcdLimit(DIGITS);
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int SCR_W = 4 * DIGITS;

  conv_state_t r_state;
  conv_state_t w_nextState;

  logic [CNT_W-1:0] r_count;
  logic [BIN_W-1:0] r_shiftReg;
  logic [SCR_W-1:0] r_scratch;
  logic             r_ovfNext;
  logic [SCR_W-1:0] r_bcd;
  logic             r_ovf;
  logic             r_outValid;

  logic             w_over;
  logic [BIN_W-1:0] w_clamped;
  logic             w_accept;
  logic             w_lastShift;
  logic [SCR_W-1:0] w_adjusted;

  assign w_over      = (32'(i_bin) > LIMIT);
  assign w_clamped   = w_over ? BIN_W'(LIMIT) : i_bin;
  assign w_lastShift = (r_count == CNT_W'(BIN_W - 1));

  // Ready is held low during the out_valid cycle too, giving one conversion per BIN_W+2 clocks.
  assign o_in_ready  = (r_state == IDLE) && !r_outValid;
  assign o_busy      = ~o_in_ready;
  assign w_accept    = o_in_ready && i_in_valid;

  assign o_out_valid = r_outValid;
  assign o_bcd       = r_bcd;
  assign o_ovf       = r_ovf;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_scratch[4*g +: 4]),
      .o_digit (w_adjusted[4*g +: 4])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = SHIFT;
      SHIFT:   if (w_lastShift) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The clamped value never needs a fifth digit, so bits shifted out of the scratch top are always zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count    <= '0;
      r_shiftReg <= '0;
      r_scratch  <= '0;
      r_ovfNext  <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shiftReg <= w_clamped;
            r_ovfNext  <= w_over;
            r_scratch  <= '0;
            r_count    <= '0;
          end
        end
        SHIFT: begin
          {r_scratch, r_shiftReg} <= {w_adjusted, r_shiftReg} << 1;
          r_count                 <= r_count + CNT_W'(1);
        end
        DONE: begin
          r_bcd      <= r_scratch;
          r_ovf      <= r_ovfNext;
          r_outValid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: the driver queues expected results, a monitor checks every out_valid.
// Expected BCD comes from hand-written constants or a decimal digit-split reference.
module tb_bin2bcd_seq;
  import stopwatch_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             inValid = 1'b0;
  logic [T_W-1:0]   bin = '0;
  logic             inReady;
  logic             outValid;
  logic [BCD_W-1:0] bcd;
  logic             ovf;
  logic             busy;

  typedef struct {
    logic [BCD_W-1:0] bcd;
    logic             ovf;
    int               acceptEdge;
  } exp_t;

  exp_t expQ[$];
  int   compareCount = 0;
  int   failCount    = 0;
  int   edgeCount    = 0;
  int   acceptCount  = 0;
  int   pulseCount   = 0;
  logic prevValid    = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  bin2bcd_seq #(.BIN_W(T_W), .DIGITS(NUM_DIGITS)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_bin       (bin),
    .o_out_valid (outValid),
    .o_bcd       (bcd),
    .o_ovf       (ovf),
    .o_busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [BCD_W-1:0] refBcd(input int value);
    int c;
    c = (value > BCD_MAX) ? BCD_MAX : value;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  // Called at a negedge; waits for ready, presents one value for one edge, returns at the next negedge.
  task automatic applyStimulus(input logic [T_W-1:0] value, input logic [BCD_W-1:0] expBcd,
                               input logic expOvf, input bit expectResult);
    int   waitCycles;
    exp_t e;
    waitCycles = 0;
    while (inReady !== 1'b1 && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (inReady !== 1'b1) begin
      compareCount++;
      failCount++;
      $display("[TB] FAIL ready-timeout: in_ready=%b, expected 1", inReady);
    end
    inValid = 1'b1;
    bin     = value;
    if (expectResult) begin
      e.bcd        = expBcd;
      e.ovf        = expOvf;
      e.acceptEdge = edgeCount + 1;
      expQ.push_back(e);
      acceptCount++;
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (outValid === 1'b1) begin
        pulseCount++;
        checkOutput("out_valid one cycle", 32'(prevValid), 32'd0);
        if (expQ.size() == 0) begin
          compareCount++;
          failCount++;
          $display("[TB] FAIL unexpected out_valid: bcd=%h, expected no result", bcd);
        end else begin
          e = expQ.pop_front();
          checkOutput("bcd", 32'(bcd), 32'(e.bcd));
          checkOutput("ovf", 32'(ovf), 32'(e.ovf));
          checkOutput("latency", 32'(edgeCount - e.acceptEdge), 32'd15);
        end
      end
      prevValid = outValid;
    end
  end

  initial begin
    int lowCycles;
    int drainCycles;

    // Reset held together with in_valid: nothing may be accepted.
    rst     = 1'b1;
    inValid = 1'b1;
    bin     = 14'd1234;
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    inValid = 1'b0;
    checkOutput("reset in_ready", 32'(inReady), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset bcd", 32'(bcd), 32'h0000);
    checkOutput("reset ovf", 32'(ovf), 32'd0);

    applyStimulus(14'd0, 16'h0000, 1'b0, 1'b1);

    applyStimulus(14'd1234, 16'h1234, 1'b0, 1'b1);
    checkOutput("busy while converting", 32'(busy), 32'd1);
    lowCycles = 0;
    while (inReady !== 1'b1 && lowCycles < 40) begin
      lowCycles++;
      @(negedge clk);
    end
    checkOutput("in_ready low cycles", 32'(lowCycles), 32'd16);
    checkOutput("busy after return", 32'(busy), 32'd0);

    applyStimulus(14'd9999, 16'h9999, 1'b0, 1'b1);
    applyStimulus(14'd10000, 16'h9999, 1'b1, 1'b1);
    applyStimulus(14'd16383, 16'h9999, 1'b1, 1'b1);

    // 42 is held on the input throughout the 57 conversion and must only be taken afterwards.
    while (inReady !== 1'b1) @(negedge clk);
    inValid = 1'b1;
    bin     = 14'd57;
    expQ.push_back('{16'h0057, 1'b0, edgeCount + 1});
    acceptCount++;
    @(negedge clk);
    bin = 14'd42;
    applyStimulus(14'd42, 16'h0042, 1'b0, 1'b1);

    // Reset during the seventh SHIFT cycle discards the 321 conversion.
    applyStimulus(14'd8765, 16'h8765, 1'b0, 1'b1);
    applyStimulus(14'd321, 16'h0321, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid-shift reset bcd", 32'(bcd), 32'h0000);
    checkOutput("mid-shift reset ovf", 32'(ovf), 32'd0);
    checkOutput("mid-shift reset out_valid", 32'(outValid), 32'd0);
    checkOutput("mid-shift reset in_ready", 32'(inReady), 32'd1);
    checkOutput("mid-shift reset busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);

    // Back-to-back sweep over the interesting ranges plus a coarse stride.
    for (int v = 0; v <= 40; v++) applyStimulus(14'(v), refBcd(v), 1'b0, 1'b1);
    for (int v = 95; v <= 105; v++) applyStimulus(14'(v), refBcd(v), 1'b0, 1'b1);
    for (int v = 990; v <= 1010; v++) applyStimulus(14'(v), refBcd(v), 1'b0, 1'b1);
    for (int v = 9990; v <= 10010; v++) applyStimulus(14'(v), refBcd(v), (v > BCD_MAX), 1'b1);
    for (int v = 16370; v <= 16383; v++) applyStimulus(14'(v), refBcd(v), 1'b1, 1'b1);
    for (int i = 1; i <= 26; i++) applyStimulus(14'(i * 613), refBcd(i * 613), (i * 613 > BCD_MAX), 1'b1);

    drainCycles = 0;
    while (expQ.size() != 0 && drainCycles < 50) begin
      @(negedge clk);
      drainCycles++;
    end
    repeat (3) @(negedge clk);
    checkOutput("outstanding results", 32'(expQ.size()), 32'd0);
    checkOutput("out_valid count", 32'(pulseCount), 32'(acceptCount));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter between the stopwatch datapath's 14-bit count `T` and the four-digit time-multiplexed display. It replaces the combinational `%10`/`/10` digit split with a shift-and-add-3 (double-dabble) engine: one input bit per clock, behind a valid/ready handshake. Values above the display range saturate to 9999 and raise a flag.

## Interface
- `BIN_W`, default 14: binary input width; also the number of shift cycles per conversion.
- `DIGITS`, default 4: BCD digits produced; the saturation limit is 10^DIGITS−1 (9999).
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `bin` is valid this cycle.
- `in_ready`, output, 1: converter can accept an input.
- `bin`, input, BIN_W: unsigned binary value.
- `out_valid`, output, 1: one-cycle pulse; `bcd`/`ovf` just updated.
- `bcd`, output, 4*DIGITS: packed BCD result, digit 0 (ones) in [3:0]; held between results.
- `ovf`, output, 1: last accepted `bin` exceeded 9999; held with `bcd`.
- `busy`, output, 1: conversion in progress (equals ~`in_ready`).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - Accept on `in_valid`=1: latch `min(bin, 9999)` into the shift register; latch `ovf_next` = (`bin` > 9999); clear the BCD scratch; count=0; go to SHIFT.
  - `in_valid`=0: stay in IDLE.
- SHIFT, each cycle:
  - For each scratch digit ≥5, add 3 (digit-wise, all digits in parallel).
  - Then shift {scratch, binary} left by 1; count++.
  - After BIN_W shifts (count==BIN_W−1 on this edge), go to DONE.
- DONE:
  - Register scratch into `bcd` and `ovf_next` into `ovf`; `out_valid`=1 for this one cycle.
  - Next state: IDLE.
- `in_valid` outside IDLE is ignored, not queued. The upstream holds or re-presents the value.
- Arithmetic:
  - Clamping before conversion means the scratch never exceeds 4*DIGITS bits. No 5th digit exists.
  - Each add-3 operates on a 4-bit digit with no carry into the neighbouring digit.
- Reset, at any state including mid-SHIFT:
  - State → IDLE; count, scratch and shift register cleared.
  - `bcd`=0, `ovf`=0, `out_valid`=0.
  - The in-flight conversion is discarded and produces no `out_valid`.
- Reset and `in_valid` asserted together: reset wins; nothing is accepted.

## Timing
- Reset values:
  - `in_ready`=1, `busy`=0.
  - `out_valid`=0, `bcd`=16'h0000, `ovf`=0.
- Accept edge k (IDLE, `in_valid`=1):
  - Edges k+1 … k+14 are the SHIFT edges.
  - DONE is occupied during the cycle after edge k+14.
  - `bcd`, `ovf` and `out_valid` are registered and visible after edge k+15.
- Latency: 15 clocks from accept to `out_valid`.
- `out_valid` is high exactly one cycle.
- `in_ready` returns to 1 the cycle after `out_valid`. Maximum throughput is one conversion per 16 clocks.
- `in_ready`, `busy` and `out_valid` are decoded from the registered state only; no combinational path from `in_valid`.
- `bcd` changes only on the DONE-exit edge or on reset. The display may sample it at any time without tearing.

## Structure
- Shared package `stopwatch_pkg`:
  - State encoding IDLE/SHIFT/DONE.
  - `T_W`=14, `NUM_DIGITS`=4, `BCD_MAX`=9999.
  - Packed BCD width constant, so the datapath, this block and the display agree.
- One natural sub-module: `bcd_add3`, a combinational 4-bit "if ≥5 add 3" cell, instantiated DIGITS times in a generate loop.
- Count register width: $clog2(BIN_W).

## Test plan
- After reset, `bin`=0 with `in_valid` pulsed → `out_valid` 15 clocks later; `bcd`=16'h0000, `ovf`=0.
- `bin`=1234 → `bcd`=16'h1234, `ovf`=0 on the 15th clock. `in_ready`=0 for 16 cycles, then 1.
- Boundary values:
  - `bin`=9999 → 16'h9999, `ovf`=0.
  - `bin`=10000 → 16'h9999, `ovf`=1.
  - `bin`=16383 → 16'h9999, `ovf`=1.
- `bin`=57 accepted, then `in_valid` held high with `bin`=42 during SHIFT → result 16'h0057. Next conversion accepts 42 only after `in_ready` returns → 16'h0042.
- Convert 8765, then assert `rst` at SHIFT cycle 7 of a second conversion (`bin`=321):
  - `bcd` drops to 0 after the reset edge.
  - No `out_valid` for 321; `in_ready`=1 next cycle.
- Exhaustive sweep 0…16383 back-to-back (drive `in_valid` whenever `in_ready`):
  - Every result equals the reference digit split of min(`bin`, 9999).
  - `ovf` set exactly for `bin` > 9999.
  - Exactly one `out_valid` per accept.
